// File: rtl/serial_shift_port.sv
// Word-oriented SPI mode-0 style slave port: synchronises the pins, frames words
// on chip select and exchanges a transmit holding register for each received word.

module ssp_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= {STAGES{RST_VAL}};
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

module serial_shift_port #(
  parameter int WIDTH       = 8,
  parameter bit LSB_FIRST   = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_in,
  input  logic             cs_n_in,
  input  logic             mosi_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_ready,
  output logic             busy
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int               CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  // pin order {mosi, cs_n, sclk}; cs_n idles high
  localparam logic [2:0]       PIN_RST = 3'b010;

  logic [2:0] pin_raw, pin_s;
  assign pin_raw = {mosi_in, cs_n_in, sclk_in};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    ssp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(PIN_RST[i])) u_sync (
      .clk(clk), .reset(reset), .d(pin_raw[i]), .q(pin_s[i])
    );
  end

  logic sclk_q, cs_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      sclk_q <= pin_s[0];
      cs_q   <= pin_s[1];
    end
  end

  assign sclk_rise = pin_s[0] & ~sclk_q;
  assign sclk_fall = ~pin_s[0] & sclk_q;
  assign cs_fall   = ~pin_s[1] & cs_q;
  assign cs_rise   = pin_s[1] & ~cs_q;

  state_t           state;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg, hold, shifted;
  logic             sample, tx_pending;

  assign shifted = LSB_FIRST ? {sample, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], sample};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      hold       <= '0;
      sample     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_pending <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state  <= ACTIVE;
            bitcnt <= '0;
            if (tx_pending) begin
              shreg      <= hold;
              tx_pending <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state  <= IDLE;
            bitcnt <= '0;
          end else if (sclk_rise) begin
            sample <= pin_s[2];
          end else if (sclk_fall) begin
            if (bitcnt == LAST) begin
              bitcnt   <= '0;
              rx_data  <= shifted;
              rx_valid <= 1'b1;
              if (tx_pending) begin
                shreg      <= hold;
                tx_pending <= 1'b0;
              end else begin
                shreg <= shifted;
              end
            end else begin
              bitcnt <= bitcnt + 1'b1;
              shreg  <= shifted;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // a same-cycle load lands after any consume, so the new word stays pending
      if (load) begin
        hold       <= load_data;
        tx_pending <= 1'b1;
      end
    end
  end

  assign miso     = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  assign busy     = (state == ACTIVE);
  assign tx_ready = ~tx_pending;
endmodule

// File: tb/tb_serial_shift_port.sv
// Drives an MSB-first and an LSB-first port with one SPI master and checks both
// against a word-level model of the exchange.

module tb_serial_shift_port;
  localparam int W    = 8;
  localparam int HALF = 6;

  logic clk = 1'b0, reset = 1'b1;
  logic sclk_in = 1'b0, cs_n_in = 1'b1, mosi_in = 1'b0, load = 1'b0;
  logic [W-1:0] load_data = '0;
  logic [1:0]   miso, rx_valid, tx_ready, busy;
  logic [W-1:0] rx_data [2];

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  serial_shift_port #(.WIDTH(W), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) u_msb (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
    .load(load), .load_data(load_data), .miso(miso[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .tx_ready(tx_ready[0]), .busy(busy[0]));

  serial_shift_port #(.WIDTH(W), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) u_lsb (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
    .load(load), .load_data(load_data), .miso(miso[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .tx_ready(tx_ready[1]), .busy(busy[1]));

  // model: outgoing word per lane, shared holding register, bit position in word
  logic [W-1:0] m_out [2];
  logic [W-1:0] m_rx  [2];
  logic [W-1:0] m_hold;
  bit           m_pend, m_busy;
  int           m_idx;
  int           settle;
  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] obs [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (settle > 0) settle--;
    for (int l = 0; l < 2; l++) begin
      if (rx_valid[l] === 1'b1) begin
        if ((l == 0 && q0.size() == 0) || (l == 1 && q1.size() == 0))
          chk(l == 0 ? "rx_valid_spurious_msb" : "rx_valid_spurious_lsb", rx_valid[l], 0);
        else begin
          e = (l == 0) ? q0.pop_front() : q1.pop_front();
          chk(l == 0 ? "rx_word_msb" : "rx_word_lsb", rx_data[l], e);
        end
      end
      if (!reset && settle == 0) begin
        chk("busy", busy[l], m_busy);
        chk("tx_ready", tx_ready[l], !m_pend);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_out[0] = '0; m_out[1] = '0; m_rx[0] = '0; m_rx[1] = '0;
    m_hold = '0; m_pend = 0; m_busy = 0; m_idx = 0;
    q0.delete(); q1.delete();
  endtask

  task automatic check_reset_vals();
    for (int l = 0; l < 2; l++) begin
      chk("rst_miso", miso[l], 0);
      chk("rst_rx_data", rx_data[l], 0);
      chk("rst_rx_valid", rx_valid[l], 0);
      chk("rst_tx_ready", tx_ready[l], 1);
      chk("rst_busy", busy[l], 0);
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_data = v; load = 1'b1;
    m_hold = v; m_pend = 1; settle = HALF;
    tick(1);
    load = 1'b0;
  endtask

  task automatic cs_low();
    cs_n_in = 1'b0; settle = HALF; m_busy = 1;
    if (m_pend) begin
      m_out[0] = m_hold; m_out[1] = m_hold; m_pend = 0;
    end
    m_idx = 0; m_rx[0] = '0; m_rx[1] = '0;
    tick(HALF);
  endtask

  task automatic cs_high();
    int k;
    cs_n_in = 1'b1; settle = HALF; m_busy = 0;
    k = m_idx;
    if (k != 0) begin
      m_out[0] = (m_out[0] << k) | (m_rx[0] >> (W - k));
      m_out[1] = (m_out[1] >> k) | (m_rx[1] << (W - k));
    end
    m_idx = 0;
    tick(HALF);
  endtask

  task automatic sclk_bit(input logic b, input bit do_ld, input logic [W-1:0] ld);
    mosi_in = b;
    tick(HALF);
    chk("miso_msb", miso[0], m_out[0][W-1-m_idx]);
    chk("miso_lsb", miso[1], m_out[1][m_idx]);
    obs[0] = {obs[0][W-2:0], miso[0]};
    obs[1] = {obs[1][W-2:0], miso[1]};
    sclk_in = 1'b1; settle = HALF;
    tick(2);
    if (do_ld) do_load(ld);
    else tick(1);
    tick(HALF - 3);
    sclk_in = 1'b0; settle = HALF;
    m_rx[0] = m_rx[0] | (W'(b) << (W - 1 - m_idx));
    m_rx[1] = m_rx[1] | (W'(b) << m_idx);
    m_idx++;
    if (m_idx == W) begin
      q0.push_back(m_rx[0]); q1.push_back(m_rx[1]);
      m_out[0] = m_pend ? m_hold : m_rx[0];
      m_out[1] = m_pend ? m_hold : m_rx[1];
      m_pend = 0; m_idx = 0; m_rx[0] = '0; m_rx[1] = '0;
    end
    tick(HALF);
  endtask

  task automatic send_word(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) sclk_bit(v[W-1-i], 0, '0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] v;
    int nw, nb;
    model_clear();
    settle = HALF;
    tick(4);
    check_reset_vals();
    reset = 1'b0;
    tick(HALF);

    // single word: tx 0x96, rx 0x3C (a bit palindrome, so both lanes receive 0x3C)
    do_load(8'h96);
    tick(2);
    chk("tx_ready_loaded", tx_ready[0], 0);
    cs_low();
    chk("tx_ready_after_csfall", tx_ready[0], 1);
    chk("busy_active", busy[1], 1);
    send_word(8'h3C);
    cs_high();
    chk("obs_msb_word", obs[0], 8'h96);
    chk("obs_lsb_word", obs[1], 8'h69);
    chk("rx_literal_msb", rx_data[0], 8'h3C);
    chk("rx_literal_lsb", rx_data[1], 8'h3C);

    // two-word frame, second word loaded during word 1
    do_load(8'h96);
    cs_low();
    v = W'($urandom);
    for (int i = 0; i < W; i++) sclk_bit(v[W-1-i], i == 2, 8'h5A);
    send_word(W'($urandom));
    cs_high();
    chk("obs_word2_msb", obs[0], 8'h5A);
    chk("obs_word2_lsb", obs[1], 8'h5A);

    // two-word frame without a second load: word 2 echoes word 1
    do_load(W'($urandom));
    cs_low();
    send_word(8'hC3);
    send_word(W'($urandom));
    cs_high();
    chk("echo_msb", obs[0], 8'hC3);

    // abort after 5 bits, then a full frame of ones
    do_load(W'($urandom));
    cs_low();
    for (int i = 0; i < 5; i++) sclk_bit(1'($urandom), 0, '0);
    cs_high();
    cs_low();
    send_word(8'hFF);
    cs_high();
    chk("after_abort_msb", rx_data[0], 8'hFF);
    chk("after_abort_lsb", rx_data[1], 8'hFF);

    // reset mid-word
    do_load(W'($urandom));
    cs_low();
    for (int i = 0; i < 3; i++) sclk_bit(1'($urandom), 0, '0);
    reset = 1'b1; cs_n_in = 1'b1; sclk_in = 1'b0;
    model_clear();
    tick(2);
    check_reset_vals();
    tick(3);
    reset = 1'b0; settle = HALF;
    tick(HALF);

    // sclk toggling with cs high must be ignored
    for (int i = 0; i < 10; i++) begin
      mosi_in = 1'($urandom);
      sclk_in = 1'b1; tick(HALF);
      sclk_in = 1'b0; tick(HALF);
    end
    chk("idle_busy", busy[0], 0);
    chk("idle_rx_data", rx_data[0], 0);

    // randomized frames with random loads and aborts
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(1, 0) == 1) do_load(W'($urandom));
      cs_low();
      nw = $urandom_range(3, 1);
      for (int w = 0; w < nw; w++)
        for (int i = 0; i < W; i++)
          sclk_bit(1'($urandom), $urandom_range(7, 0) == 0, W'($urandom));
      if ($urandom_range(3, 0) == 0) begin
        nb = $urandom_range(W - 1, 1);
        for (int i = 0; i < nb; i++) sclk_bit(1'($urandom), 0, '0);
      end
      cs_high();
    end

    tick(HALF);
    chk("rx_missing_msb", q0.size(), 0);
    chk("rx_missing_lsb", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_shift_port.md
Name: serial_shift_port

Overview:
- Parametrised successor to the bring-up shift register: a word-oriented serial port for an external peripheral-clock master (SPI mode 0 style).
- Integrates synchronisers and edge detectors for the peripheral clock, chip-select and serial-in lines.
- Adds chip-select framing, a bit counter, MSB/LSB-first selection, a transmit holding register and a received-word strobe.
- Sits between the board GPIO pins and the fabric logic, replacing the separate conditioner-plus-shift-register arrangement.

Parameters:
- WIDTH, 8: word length in bits; must be 2 or more.
- LSB_FIRST, 0: 0 shifts MSB first; 1 shifts LSB first.
- SYNC_STAGES, 2: synchroniser flops per asynchronous input; must be 2 or more.

Ports:
- clk  input  1  fabric clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sclk_in  input  1  asynchronous peripheral clock.
- cs_n_in  input  1  asynchronous chip select, active low.
- mosi_in  input  1  asynchronous serial data in.
- load  input  1  one-cycle strobe; writes load_data into the transmit holding register.
- load_data  input  WIDTH  next transmit word.
- miso  output  1  serial data out.
- rx_data  output  WIDTH  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_ready  output  1  high when the holding register is empty.
- busy  output  1  high while in ACTIVE.

Behaviour:
- Reset values:
  - Synchronisers: sclk and mosi to 0, cs_n to 1.
  - State IDLE; bit counter 0.
  - Shift register, holding register, rx_data and sample bit all 0.
  - rx_valid 0; tx_pending 0, so tx_ready is 1; busy 0.
- Synchronisers and edge detection:
  - Each async input passes through SYNC_STAGES flops.
  - sclk_rise and sclk_fall are single-cycle pulses derived from the synchronised sclk against its previous value. cs_fall and cs_rise are derived the same way.
  - Latency from pin transition to edge pulse is SYNC_STAGES+1 clk cycles.
- miso:
  - shreg[WIDTH-1] when LSB_FIRST=0; shreg[0] when LSB_FIRST=1.
  - Driven continuously. Tristating is external.
- State IDLE:
  - sclk edges are ignored.
  - On cs_fall: go to ACTIVE and clear the bit counter.
  - If tx_pending is set on cs_fall: shreg <= hold and tx_pending is cleared. Otherwise shreg is retained.
- State ACTIVE:
  - On sclk_rise: sample bit <= synchronised mosi.
  - On sclk_fall, LSB_FIRST=0: shreg <= {shreg[WIDTH-2:0], sample}.
  - On sclk_fall, LSB_FIRST=1: shreg <= {sample, shreg[WIDTH-1:1]}.
  - Every sclk_fall increments the bit counter.
- Word boundary (sclk_fall that completes bit WIDTH):
  - rx_data <= the newly shifted value; rx_valid pulses in the following cycle.
  - The bit counter wraps to 0 and the state stays ACTIVE, so multi-word frames continue.
  - In that same update, shreg is replaced by hold if tx_pending was set (tx_pending then clears). Otherwise the received word stays in shreg and is echoed back on the next word.
- cs_rise in ACTIVE (abort or frame end):
  - Go to IDLE and clear the bit counter.
  - A partial word produces no rx_valid; shreg is retained.
- Load and holding register:
  - load writes hold and sets tx_pending in any state.
  - A second load while pending overwrites hold; last write wins.
  - load in the same cycle as a boundary or IDLE cs_fall: the old pending word, if any, is consumed, then the new word becomes pending. If nothing was pending, the new word is not used until the next boundary.
- Simultaneous events:
  - A cs edge takes precedence; an sclk edge in the same cycle is ignored.
  - reset overrides everything, including mid-word operation, and aborts with no rx_valid.
- Outputs: busy = (state == ACTIVE); tx_ready = ~tx_pending.

Test Plan:
1. WIDTH=8, LSB_FIRST=0: load 0x96, cs low, 8 sclk pulses with mosi carrying 0x3C MSB first -> miso bits 1,0,0,1,0,1,1,0; rx_data=0x3C; rx_valid high for exactly 1 cycle; tx_ready 0 to 1 at cs_fall.
2. LSB_FIRST=1: same stimulus with mosi carrying 0x3C LSB first -> miso bits 0,1,1,0,1,0,0,1; rx_data=0x3C.
3. Two-word frame: load 0x96, then load 0x5A during word 1, 16 sclk pulses -> word 2 miso shows 0x5A; two rx_valid pulses.
4. Two-word frame with no second load -> word 2 miso echoes word-1 received data.
5. cs high after 5 sclk pulses, then a new frame with 8 pulses of 0xFF -> no rx_valid on the abort; the next rx_data=0xFF; bit counter restarted.
6. reset asserted mid-word, and separately sclk toggling with cs high -> all outputs at reset values, and no rx_valid from the idle sclk toggling.
